// File: rtl/shadow_capture_pkg.sv
// Shared constants for the shadow-capture chain controller: state encoding,
// default geometry and a width helper.
package shadow_capture_pkg;

   localparam int unsigned DEF_WIDTH     = 1;
   localparam int unsigned DEF_CHAIN_LEN = 16;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CAPTURE  = 3'd1;
   localparam logic [2:0] ST_WAIT_RDY = 3'd2;
   localparam logic [2:0] ST_DUMP     = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Ceiling log2, never below 1 so it can size a counter directly.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/shadow_capture_wdog.sv
// WAIT_RDY watchdog: cleared by load_i, counts while en_i, and flags expiry
// combinationally in the TIMEOUT-th enabled cycle.
module shadow_capture_wdog
   import shadow_capture_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_c_o
);

   localparam int unsigned   TW     = clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign expired_c_o = en_i && (cnt_q == T_LAST);

   // Next count: reload on load, saturate once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_c_o) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/shadow_capture_ctrl.sv
// Shadow-capture chain controller: strobes c_en, waits for all cells to
// report captured, then drains the chain tail word-by-word to the host.
// Optional WAIT_RDY watchdog enabled by defining SHADOW_CAPTURE_TIMEOUT_EN.
module shadow_capture_ctrl
   import shadow_capture_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int unsigned CNT_W     = clog2(CHAIN_LEN + 1),
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   output logic             busy,
   output logic             c_en,
   output logic             d_en,
   input  logic             q_ready_all,
   input  logic [WIDTH-1:0] chain_q,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_last,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   // Reject geometries the counter cannot represent.
   if (((64'd1 << CNT_W) <= 64'(CHAIN_LEN)) || (CHAIN_LEN == 0) || (TIMEOUT == 0)) begin : g_bad_cfg
      $error("shadow_capture_ctrl: invalid CHAIN_LEN/CNT_W/TIMEOUT");
   end

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wait_first_q, wait_first_d;
   logic             busy_q, busy_d;
   logic             c_en_q, c_en_d;
   logic             dout_valid_q, dout_valid_d;
   logic             dout_last_q, dout_last_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             accept_c;
   logic             wdog_exp_c;

`ifdef SHADOW_CAPTURE_TIMEOUT_EN
   shadow_capture_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (state_q == ST_CAPTURE),
      .en_i        (state_q == ST_WAIT_RDY),
      .expired_c_o (wdog_exp_c)
   );
`else
   assign wdog_exp_c = 1'b0;
`endif

   assign accept_c   = dout_valid_q & dout_ready;
   assign d_en       = accept_c;
   assign dout       = chain_q;
   assign busy       = busy_q;
   assign c_en       = c_en_q;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign done       = done_q;
   assign err        = err_q;

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      wait_first_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_CAPTURE;
               err_d   = 1'b0;
            end
         end
         ST_CAPTURE: begin
            state_d      = ST_WAIT_RDY;
            wait_first_d = 1'b1;
         end
         ST_WAIT_RDY: begin
            // q_ready_all may still be stale in the first WAIT_RDY cycle.
            if (!wait_first_q && q_ready_all) begin
               state_d = ST_DUMP;
               cnt_d   = '0;
            end else if (wdog_exp_c) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_DUMP: begin
            if (accept_c) begin
               if (cnt_q == CNT_LAST) state_d = ST_DONE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d       = (state_d != ST_IDLE);
      c_en_d       = (state_d == ST_CAPTURE);
      dout_valid_d = (state_d == ST_DUMP);
      dout_last_d  = (state_d == ST_DUMP) && (cnt_d == CNT_LAST);
      done_d       = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         wait_first_q <= 1'b0;
         busy_q       <= 1'b0;
         c_en_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wait_first_q <= wait_first_d;
         busy_q       <= busy_d;
         c_en_q       <= c_en_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_shadow_capture_ctrl.sv
// Directed bench for shadow_capture_ctrl (WIDTH=8, CHAIN_LEN=4, TIMEOUT=10).
// A small chain model presents tail[ptr] and shifts on d_en.
module tb_shadow_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trig;
   logic       busy, c_en, d_en;
   logic       q_ready_all;
   logic [7:0] chain_q;
   logic [7:0] dout;
   logic       dout_valid, dout_ready, dout_last, done, err;

   logic [7:0] tail [8];
   logic [2:0] ptr = 3'd0;
   int         den_cnt = 0;
   int         errors = 0;
   int         checks = 0;

   shadow_capture_ctrl #(
      .WIDTH     (8),
      .CHAIN_LEN (4),
      .TIMEOUT   (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .trig        (trig),
      .busy        (busy),
      .c_en        (c_en),
      .d_en        (d_en),
      .q_ready_all (q_ready_all),
      .chain_q     (chain_q),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .dout_last   (dout_last),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Chain model: capture rewinds to the first word, each d_en shifts one.
   assign chain_q = tail[ptr];
   always @(posedge clk) begin
      if (c_en)      ptr <= 3'd0;
      else if (d_en) ptr <= ptr + 3'd1;
      if (d_en) den_cnt <= den_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tail(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      tail[0] = a; tail[1] = b; tail[2] = c; tail[3] = d;
   endtask

   // Trigger a capture; q_ready_all stays low rdy_delay cycles after capture
   // (0 = left high from a previous run). Returns in the first DUMP cycle.
   task automatic start_capture(input int rdy_delay);
      trig = 1'b1;
      tick();
      check("c_en_pulse", 32'(c_en), 32'd1);
      check("busy_capture", 32'(busy), 32'd1);
      check("err_clear", 32'(err), 32'd0);
      trig = 1'b0;
      if (rdy_delay > 0) q_ready_all = 1'b0;
      tick();
      check("c_en_one_cycle", 32'(c_en), 32'd0);
      check("wait1_no_valid", 32'(dout_valid), 32'd0);
      tick();
      check("wait2_no_valid", 32'(dout_valid), 32'd0);
      for (int i = 1; i < rdy_delay; i++) begin
         tick();
         check("wait_rdy_low", 32'(dout_valid), 32'd0);
      end
      q_ready_all = 1'b1;
      tick();
      check("dump_entry", 32'(dout_valid), 32'd1);
   endtask

   // Drain with ready pattern pat (bit i = cycle i); ends in the DONE cycle.
   task automatic drain(input logic [15:0] pat, input int n);
      int k  = 0;
      int d0 = den_cnt;
      for (int i = 0; i < n; i++) begin
         dout_ready = pat[i];
         #1;
         check("dump_valid", 32'(dout_valid), 32'd1);
         check("d_en", 32'(d_en), 32'(pat[i]));
         check("dout_word", 32'(dout), 32'(tail[k]));
         check("dout_last", 32'(dout_last), (k == 3) ? 32'd1 : 32'd0);
         tick();
         if (pat[i]) k++;
      end
      check("d_en_count", 32'(den_cnt - d0), 32'd4);
      check("done_pulse", 32'(done), 32'd1);
      check("done_valid_low", 32'(dout_valid), 32'd0);
      dout_ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; trig = 1'b0; q_ready_all = 1'b0; dout_ready = 1'b1;
      for (int i = 0; i < 8; i++) tail[i] = 8'h00;
      #23 rst_n = 1'b1;

      // Reset then idle.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_outs", 32'({busy, c_en, d_en, dout_valid, dout_last, done, err}), 32'd0);
      end

      // Basic dump; trig during DONE must be ignored.
      set_tail(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      start_capture(1);
      drain(16'h000F, 4);
      trig = 1'b1;
      tick();
      check("trig_in_done_busy", 32'(busy), 32'd0);
      check("trig_in_done_c_en", 32'(c_en), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
      trig = 1'b0;
      tick();
      check("trig_not_queued", 32'(c_en), 32'd0);

      // Stale q_ready_all plus backpressure 1,0,0,1,0,1,1.
      set_tail(8'h11, 8'h22, 8'h33, 8'h44);
      start_capture(0);
      drain(16'h0069, 7);
      tick();
      check("bp_idle", 32'({busy, done}), 32'd0);

      // Trig during DUMP ignored, then async reset at word 2.
      set_tail(8'h5A, 8'h6B, 8'h7C, 8'h8D);
      start_capture(3);
      dout_ready = 1'b1;
      trig = 1'b1;
      #1;
      check("rst_word0", 32'(dout), 32'h5A);
      tick();
      trig = 1'b0;
      check("rst_word1", 32'(dout), 32'h6B);
      check("trig_busy_ignored", 32'(c_en), 32'd0);
      tick();
      check("rst_word2", 32'(dout), 32'h7C);
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'({d_en, dout_valid, busy, c_en, dout_last}), 32'd0);
      #1 rst_n = 1'b1;
      tick();
      check("post_reset_idle", 32'({busy, c_en, dout_valid}), 32'd0);
      set_tail(8'hE1, 8'hF2, 8'h03, 8'h14);
      start_capture(1);
      drain(16'h000F, 4);
      tick();
      check("redump_idle", 32'({busy, done}), 32'd0);

`ifdef SHADOW_CAPTURE_TIMEOUT_EN
      // Watchdog: q_ready_all never rises.
      q_ready_all = 1'b0;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      check("to_c_en", 32'(c_en), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("to_waiting", 32'({err, dout_valid, busy}), 32'b001);
      end
      tick();
      check("to_err_set", 32'({err, dout_valid, busy, done}), 32'b1000);
      tick();
      check("to_err_sticky", 32'({err, busy}), 32'b10);
      start_capture(1);
      drain(16'h000F, 4);
      tick();
`else
      check("err_tied_low", 32'(err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
